// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types for the pipeline hazard controller.
// State encoding, address widths and the pipeline-control bundle, plus
// helpers that build the common control patterns.
package hazard_ctrl_pkg;

    localparam int STATE_W    = 2;
    localparam int REG_ADDR_W = 5;

    // Encoding 3 is unreachable and is decoded as ERROR.
    typedef enum logic [STATE_W-1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    // Controls driven into the pipeline registers.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_hold;
    } ctrl_t;

    // Everything frozen: nothing advances, nothing is cleared.
    function automatic ctrl_t ctrl_freeze();
        ctrl_t c;
        c = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
              idex_bubble: 1'b0, pipe_hold: 1'b1};
        return c;
    endfunction

    // Values presented while reset is held.
    function automatic ctrl_t ctrl_reset();
        ctrl_t c;
        c = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
              idex_bubble: 1'b1, pipe_hold: 1'b1};
        return c;
    endfunction

    // Free-running pipeline with load-use and branch resolution.
    // Load-use wins over the branch: the branch sits in ID again next cycle
    // and is re-evaluated, so flushing now would drop it.
    function automatic ctrl_t ctrl_run(input logic load_use, input logic br_taken);
        ctrl_t c;
        c = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
              idex_bubble: 1'b0, pipe_hold: 1'b0};
        if (load_use) begin
            c.pc_write    = 1'b0;
            c.ifid_write  = 1'b0;
            c.idex_bubble = 1'b1;
        end else if (br_taken) begin
            c.ifid_flush  = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: enable-gated up counter that saturates at all-ones.
module hazard_perf_cnt
    import hazard_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // Count enabled cycles, sticking at the maximum value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage MIPS core.
// Resolves load-use hazards, taken-branch flushes and multi-cycle data
// memory stalls, with a watchdog that traps a memory access that never
// completes. Outputs are Mealy and act in the cycle the condition is seen.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall-cycle and flush
// counters (stall_cyc_o, flush_cnt_o).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  IDEX_MemRead_i,
    input  logic [REG_ADDR_W-1:0] IDEX_RTaddr_i,
    input  logic [REG_ADDR_W-1:0] IFID_RSaddr_i,
    input  logic [REG_ADDR_W-1:0] IFID_RTaddr_i,
    input  logic                  Branch_taken_i,
    input  logic                  Dmem_req_i,
    input  logic                  Dmem_ack_i,
    output logic                  PC_write_o,
    output logic                  IFID_write_o,
    output logic                  IFID_flush_o,
    output logic                  IDEX_bubble_o,
    output logic                  pipe_hold_o,
    output logic [STATE_W-1:0]    state_o,
    output logic                  err_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cyc_o,
    output logic [CNT_W-1:0]      flush_cnt_o
`endif
);

    // Watchdog width: the ERROR transition fires at MEM_TIMEOUT-1, so the
    // counter never needs to reach MEM_TIMEOUT and cannot wrap.
    localparam int               WD_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(MEM_TIMEOUT - 1);

    // Reject configurations the watchdog cannot represent.
    if (MEM_TIMEOUT < 2) begin : g_bad_timeout
        $error("hazard_ctrl: MEM_TIMEOUT must be >= 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hazard_ctrl: CNT_W must be >= 1");
    end

    state_t          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    ctrl_t           ctrl;

    logic stall_c;
    logic load_use_c;
    logic in_error;

    assign stall_c    = Dmem_req_i && !Dmem_ack_i;
    assign load_use_c = IDEX_MemRead_i && (IDEX_RTaddr_i != '0) &&
                        ((IDEX_RTaddr_i == IFID_RSaddr_i) ||
                         (IDEX_RTaddr_i == IFID_RTaddr_i));
    // ERROR and the illegal encoding 3 both have the top bit set.
    assign in_error   = state_q[1];

    // State and watchdog registers; reset aborts any wait or trap at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    // Next state: enter MEM_WAIT on a stall, leave on ack, trap on timeout.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        case (state_q)
            RUN: begin
                if (stall_c) begin
                    state_d = MEM_WAIT;
                    wd_d    = '0;
                end
            end
            MEM_WAIT: begin
                // Ack in the final timeout cycle still returns to RUN.
                if (Dmem_ack_i) begin
                    state_d = RUN;
                end else if (wd_q == WD_LAST) begin
                    state_d = ERROR;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = ERROR;
            end
        endcase
    end

    // Mealy pipeline controls from state and current hazard inputs.
    always_comb begin
        ctrl = ctrl_run(1'b0, 1'b0);
        if (rst_i) begin
            ctrl = ctrl_reset();
        end else begin
            case (state_q)
                RUN: begin
                    if (stall_c) ctrl = ctrl_freeze();
                    else         ctrl = ctrl_run(load_use_c, Branch_taken_i);
                end
                MEM_WAIT: begin
                    if (!Dmem_ack_i) ctrl = ctrl_freeze();
                    else             ctrl = ctrl_run(load_use_c, Branch_taken_i);
                end
                default: begin
                    ctrl = ctrl_freeze();
                end
            endcase
        end
    end

    assign PC_write_o    = ctrl.pc_write;
    assign IFID_write_o  = ctrl.ifid_write;
    assign IFID_flush_o  = ctrl.ifid_flush;
    assign IDEX_bubble_o = ctrl.idex_bubble;
    assign pipe_hold_o   = ctrl.pipe_hold;
    assign state_o       = state_q;
    assign err_o         = in_error;

`ifdef HAZARD_PERF_CNT_EN
    logic stall_cnt_en;
    logic flush_cnt_en;

    // Stalled cycles exclude reset and the trapped state.
    assign stall_cnt_en = !rst_i && !in_error && !ctrl.pc_write;
    assign flush_cnt_en = !rst_i && ctrl.ifid_flush;

    hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (stall_cnt_en),
        .cnt_o (stall_cyc_o)
    );

    hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (flush_cnt_en),
        .cnt_o (flush_cnt_o)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4).
// The driver applies one vector per cycle just after the rising edge and
// queues the hand-computed response; the monitor pops and compares on the
// falling edge.
module tb_hazard_ctrl;

    localparam int T     = 4;
    localparam int CNT_W = 32;

    // Expected control patterns, ordered {pc, ifid_w, flush, bubble, hold}.
    localparam logic [4:0] C_RUN = 5'b11000;
    localparam logic [4:0] C_BUB = 5'b00010;
    localparam logic [4:0] C_FL  = 5'b11100;
    localparam logic [4:0] C_FRZ = 5'b00001;
    localparam logic [4:0] C_RST = 5'b00011;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       mr_i;
    logic [4:0] rt_i, rs_id_i, rt_id_i;
    logic       br_i, req_i, ack_i;
    logic       pc_o, ifw_o, fl_o, bub_o, hold_o, err_o;
    logic [1:0] st_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] sc_o, fc_o;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .IDEX_MemRead_i (mr_i),
        .IDEX_RTaddr_i  (rt_i),
        .IFID_RSaddr_i  (rs_id_i),
        .IFID_RTaddr_i  (rt_id_i),
        .Branch_taken_i (br_i),
        .Dmem_req_i     (req_i),
        .Dmem_ack_i     (ack_i),
        .PC_write_o     (pc_o),
        .IFID_write_o   (ifw_o),
        .IFID_flush_o   (fl_o),
        .IDEX_bubble_o  (bub_o),
        .pipe_hold_o    (hold_o),
        .state_o        (st_o),
        .err_o          (err_o)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cyc_o    (sc_o),
        .flush_cnt_o    (fc_o)
`endif
    );

    typedef struct {
        string       name;
        logic [4:0]  c;
        logic [1:0]  st;
        logic        err;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] m_sc   = '0;
    logic [31:0] m_fc   = '0;

    // Apply one input vector just after the rising edge.
    task automatic drive(input logic rst, input logic mr, input logic [4:0] rt,
                         input logic [4:0] rs, input logic [4:0] rtid,
                         input logic br, input logic req, input logic ack);
        @(posedge clk);
        #1;
        rst_i = rst; mr_i = mr; rt_i = rt; rs_id_i = rs; rt_id_i = rtid;
        br_i = br; req_i = req; ack_i = ack;
    endtask

    // Queue the expected response for the vector just driven and advance
    // the perf-counter model from the expected controls.
    task automatic expect_o(input string name, input logic [4:0] c,
                            input logic [1:0] st, input logic err);
        exp_t e;
        if (rst_i) begin
            m_sc = '0;
            m_fc = '0;
        end
        e.name = name; e.c = c; e.st = st; e.err = err; e.sc = m_sc; e.fc = m_fc;
        q.push_back(e);
        if (!rst_i) begin
            if (!c[4] && !st[1]) m_sc = m_sc + 1;
            if (c[2])            m_fc = m_fc + 1;
        end
    endtask

    task automatic idle_step(input string name, input logic [4:0] c,
                             input logic [1:0] st, input logic err);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_o(name, c, st, err);
    endtask

    // Monitor: compare the Mealy outputs mid-cycle against the scoreboard.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            logic ok;
            me = q.pop_front();
            n_chk = n_chk + 1;
            ok = ({pc_o, ifw_o, fl_o, bub_o, hold_o} === me.c) &&
                 (st_o === me.st) && (err_o === me.err);
`ifdef HAZARD_PERF_CNT_EN
            ok = ok && (sc_o === me.sc) && (fc_o === me.fc);
            if (!ok) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got ctl=%b st=%0d err=%b sc=%0d fc=%0d, want ctl=%b st=%0d err=%b sc=%0d fc=%0d",
                         me.name, {pc_o, ifw_o, fl_o, bub_o, hold_o}, st_o, err_o, sc_o, fc_o,
                         me.c, me.st, me.err, me.sc, me.fc);
            end
`else
            if (!ok) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got ctl=%b st=%0d err=%b, want ctl=%b st=%0d err=%b",
                         me.name, {pc_o, ifw_o, fl_o, bub_o, hold_o}, st_o, err_o,
                         me.c, me.st, me.err);
            end
`endif
        end
    end

    initial begin
        rst_i = 1'b1; mr_i = 1'b0; rt_i = '0; rs_id_i = '0; rt_id_i = '0;
        br_i = 1'b0; req_i = 1'b0; ack_i = 1'b0;

        // Reset values and release.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); expect_o("rst_hold0", C_RST, 2'd0, 1'b0);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); expect_o("rst_hold1", C_RST, 2'd0, 1'b0);
        idle_step("run_after_rst", C_RUN, 2'd0, 1'b0);

        // Load-use on rs, clear, load-use on rt, $zero destination.
        drive(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0); expect_o("lu_rs", C_BUB, 2'd0, 1'b0);
        drive(1'b0, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0); expect_o("lu_clear", C_RUN, 2'd0, 1'b0);
        drive(1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0); expect_o("lu_rt", C_BUB, 2'd0, 1'b0);
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); expect_o("lu_zero", C_RUN, 2'd0, 1'b0);
        drive(1'b0, 1'b1, 5'd7, 5'd6, 5'd5, 1'b0, 1'b0, 1'b0); expect_o("load_nomatch", C_RUN, 2'd0, 1'b0);

        // Load-use suppresses the branch flush; the re-evaluated branch flushes.
        drive(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0); expect_o("lu_br", C_BUB, 2'd0, 1'b0);
        drive(1'b0, 1'b0, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0); expect_o("br_flush", C_FL, 2'd0, 1'b0);
        idle_step("run_after_br", C_RUN, 2'd0, 1'b0);

        // Request acked in the same cycle is not a stall.
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1); expect_o("req_ack_same", C_RUN, 2'd0, 1'b0);

        // Stall outranks load-use and branch; ack after three waits.
        drive(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0); expect_o("stall_N", C_FRZ, 2'd0, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); expect_o("stall_N1", C_FRZ, 2'd1, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); expect_o("stall_N2", C_FRZ, 2'd1, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1); expect_o("stall_ack", C_RUN, 2'd1, 1'b0);
        idle_step("stall_done", C_RUN, 2'd0, 1'b0);

        // Ack coinciding with a load-use applies the bubble.
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); expect_o("ack_lu_N", C_FRZ, 2'd0, 1'b0);
        drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1); expect_o("ack_lu", C_BUB, 2'd1, 1'b0);
        idle_step("ack_lu_done", C_RUN, 2'd0, 1'b0);

        // Ack in the last allowed cycle (N+T) returns to RUN, with a branch.
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); expect_o("last_N", C_FRZ, 2'd0, 1'b0);
        for (int i = 1; i < T; i++) begin
            drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            expect_o($sformatf("last_N%0d", i), C_FRZ, 2'd1, 1'b0);
        end
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1); expect_o("last_ack_br", C_FL, 2'd1, 1'b0);
        idle_step("last_done", C_RUN, 2'd0, 1'b0);

        // Timeout: no ack, ERROR at N+T+1, sticky and deaf to inputs.
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); expect_o("to_N", C_FRZ, 2'd0, 1'b0);
        for (int i = 1; i <= T; i++) begin
            drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            expect_o($sformatf("to_N%0d", i), C_FRZ, 2'd1, 1'b0);
        end
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); expect_o("to_err", C_FRZ, 2'd2, 1'b1);
        drive(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b1, 1'b1); expect_o("err_ignore", C_FRZ, 2'd2, 1'b1);
        idle_step("err_sticky", C_FRZ, 2'd2, 1'b1);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); expect_o("err_rst", C_RST, 2'd0, 1'b0);
        idle_step("err_cleared", C_RUN, 2'd0, 1'b0);

        // Async reset mid-MEM_WAIT aborts in the same cycle.
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); expect_o("pre_flush", C_FL, 2'd0, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); expect_o("ar_N", C_FRZ, 2'd0, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); expect_o("ar_N1", C_FRZ, 2'd1, 1'b0);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); expect_o("ar_rst", C_RST, 2'd0, 1'b0);
        idle_step("ar_done", C_RUN, 2'd0, 1'b0);
        idle_step("final", C_RUN, 2'd0, 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_chk  = n_chk + 1;
            n_fail = n_fail + 1;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
